// File: rtl/adder_acc_pkg.sv
// -----------------------------------------------------------------------------
// adder_acc_pkg
// Shared types and sizing for the adder sum accumulator.
//   acc_state_e : accumulator FSM states (ACCUM collects sums, HOLD presents).
//   SUM_W_DEF   : default width of one incoming adder sum.
//   ACC_W_DEF   : default accumulator / result width.
//   cnt_w()     : width of the per-block sample counter for a given COUNT.
// -----------------------------------------------------------------------------
package adder_acc_pkg;

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } acc_state_e;

   localparam int unsigned SUM_W_DEF = 5;
   localparam int unsigned ACC_W_DEF = 12;

   // Enough bits to hold the values 0..COUNT; never narrower than one bit.
   function automatic int unsigned cnt_w(input int unsigned count);
      return (count < 2) ? 1 : $clog2(count + 1);
   endfunction

endpackage

// File: rtl/acc_block_counter.sv
// -----------------------------------------------------------------------------
// acc_block_counter
// Counts accepted sums within one block and flags the final one.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst   : synchronous active-high reset
//   i_clear : synchronous clear (block abort)
//   i_inc   : one sum accepted this cycle
//   o_cnt   : sums accepted so far in the current block
//   o_last  : o_cnt == COUNT-1, i.e. the next accept completes the block
// -----------------------------------------------------------------------------
module acc_block_counter
   import adder_acc_pkg::*;
#(
   parameter int unsigned COUNT = 8
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_clear,
   input  logic                      i_inc,
   output logic [cnt_w(COUNT)-1:0]   o_cnt,
   output logic                      o_last
);

   localparam int unsigned      CNT_W    = cnt_w(COUNT);
   localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(COUNT - 1);

   logic [CNT_W-1:0] r_cnt;

   assign o_last = (r_cnt == LAST_VAL);
   assign o_cnt  = r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clear) begin
         r_cnt <= '0;
      end else if (i_inc) begin
         // Wrap on the block-completing accept so the count reads 0 during HOLD.
         r_cnt <= o_last ? '0 : r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/adder_sum_accumulator.sv
// -----------------------------------------------------------------------------
// adder_sum_accumulator
// Accumulates COUNT consecutive adder sums into an ACC_W-bit total and presents
// the total with a sticky overflow flag on a valid/ready handshake.
// Ports:
//   clk          : clock, rising edge
//   rst          : synchronous active-high reset (priority over flush)
//   flush        : abort the current block, partial sum discarded (ACCUM only)
//   in_valid     : in_sum valid
//   in_ready     : block can accept in_sum (combinational from state and flush)
//   in_sum       : unsigned sum from the adder
//   out_valid    : out_total/out_overflow valid (registered, high in HOLD)
//   out_ready    : sink accepts the result
//   out_total    : block total modulo 2^ACC_W, held until the next block ends
//   out_overflow : a carry out of ACC_W occurred during the block
//   sample_cnt   : sums accepted so far in the current block
// -----------------------------------------------------------------------------
module adder_sum_accumulator
   import adder_acc_pkg::*;
#(
   parameter int unsigned SUM_W = SUM_W_DEF,
   parameter int unsigned ACC_W = ACC_W_DEF,
   parameter int unsigned COUNT = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [SUM_W-1:0]          in_sum,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [ACC_W-1:0]          out_total,
   output logic                      out_overflow,
   output logic [cnt_w(COUNT)-1:0]   sample_cnt
);

   localparam int unsigned CNT_W = cnt_w(COUNT);

   acc_state_e       r_state;
   acc_state_e       w_state_next;
   logic [ACC_W-1:0] r_acc;
   logic             r_ovf;
   logic [ACC_W-1:0] r_total;
   logic             r_total_ovf;

   logic             w_accept;
   logic             w_clear;
   logic             w_last;
   logic             w_carry;
   logic [ACC_W:0]   w_sum;
   logic [CNT_W-1:0] w_cnt;

   assign in_ready = (r_state == ACCUM) && !flush;
   assign w_accept = in_valid && in_ready;
   // flush is only honoured while collecting; in HOLD the result must drain.
   assign w_clear  = (r_state == ACCUM) && flush;

   // One extra bit captures the carry out of the ACC_W-bit add.
   assign w_sum   = {1'b0, r_acc} + {{(ACC_W + 1 - SUM_W){1'b0}}, in_sum};
   assign w_carry = w_sum[ACC_W];

   acc_block_counter #(
      .COUNT (COUNT)
   ) u_counter (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_clear (w_clear),
      .i_inc   (w_accept),
      .o_cnt   (w_cnt),
      .o_last  (w_last)
   );

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ACCUM:   if (w_accept && w_last) w_state_next = HOLD;
         HOLD:    if (out_ready) w_state_next = ACCUM;
         default: w_state_next = ACCUM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ACCUM;
         r_acc       <= '0;
         r_ovf       <= 1'b0;
         r_total     <= '0;
         r_total_ovf <= 1'b0;
      end else begin
         r_state <= w_state_next;
         if (w_clear) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
         end else if (w_accept) begin
            if (w_last) begin
               r_total     <= w_sum[ACC_W-1:0];
               r_total_ovf <= r_ovf | w_carry;
               r_acc       <= '0;
               r_ovf       <= 1'b0;
            end else begin
               r_acc <= w_sum[ACC_W-1:0];
               r_ovf <= r_ovf | w_carry;
            end
         end
      end
   end

   assign out_valid    = (r_state == HOLD);
   assign out_total    = r_total;
   assign out_overflow = r_total_ovf;
   assign sample_cnt   = w_cnt;

endmodule

// File: doc/adder_sum_accumulator.md
Name: adder_sum_accumulator

Overview:
- Downstream consumer of the 4-bit adder's 5-bit sum output.
- Accepts one sum per valid/ready handshake and accumulates COUNT consecutive sums into a wider total.
- Presents the total, with a sticky overflow flag, on an output valid/ready handshake, then starts a new block.
- Sits between the combinational adder datapath and any registered result sink.

Parameters:
- SUM_W, 5, width of each incoming sum; must equal the adder output width.
- ACC_W, 12, accumulator and output total width; ACC_W >= SUM_W.
- COUNT, 8, sums per block; COUNT >= 1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous abort of the current block; partial sum discarded.
- in_valid  input  1  in_sum is valid this cycle.
- in_ready  output  1  block can accept in_sum this cycle.
- in_sum  input  SUM_W  sum from the adder; treated as unsigned, zero-extended.
- out_valid  output  1  out_total and out_overflow are valid.
- out_ready  input  1  sink accepts the result.
- out_total  output  ACC_W  accumulated total, modulo 2^ACC_W.
- out_overflow  output  1  a carry out of ACC_W occurred during this block.
- sample_cnt  output  $clog2(COUNT+1)  sums accepted so far in the current block.

Behaviour:
- States:
  - ACCUM: collecting sums.
  - HOLD: result presented, waiting for the sink.
- Reset (rst=1 at a clock edge):
  - state=ACCUM; acc=0; cnt=0; ovf=0.
  - out_valid=0, out_total=0, out_overflow=0, sample_cnt=0.
  - in_ready is 1 from the first cycle after reset.
  - Reset mid-block or mid-HOLD discards everything; no result is emitted.
- Outputs:
  - in_ready = (state==ACCUM) && !flush. It is combinational from state and flush; it does not depend on in_valid.
  - out_valid = (state==HOLD); registered.
  - out_total and out_overflow are registered and stable for the whole of HOLD.
- Accept: in_valid && in_ready at a clock edge.
  - acc <= acc + in_sum.
  - ovf <= ovf | carry-out of that ACC_W-bit add.
  - cnt <= cnt+1.
- Last accept (cnt==COUNT-1):
  - out_total <= acc+in_sum; out_overflow <= ovf | carry.
  - state <= HOLD; out_valid is high in the next cycle.
  - acc, cnt and ovf are cleared in the same edge.
  - Latency from last accept to out_valid: 1 cycle.
- HOLD:
  - in_ready=0; the upstream stalls.
  - On out_valid && out_ready: state <= ACCUM; out_valid falls next cycle.
  - out_total is held (not cleared) until overwritten by the next block.
  - out_ready while in ACCUM is ignored.
- Throughput: COUNT+1 cycles per block minimum, since no input is accepted during the handshake cycle.
- flush:
  - In ACCUM: acc, cnt and ovf are cleared; any in_valid that cycle is not accepted (in_ready=0). flush wins over a simultaneous accept, including a would-be last accept.
  - In HOLD: ignored; the result must still be consumed.
  - rst has priority over flush.
- Wrap-around: the total wraps modulo 2^ACC_W; out_overflow stays sticky for the block and is cleared on the next block start.
- COUNT=1: every accept goes straight to HOLD.
- sample_cnt reads 0 in HOLD.

Decomposition:
- Shared package adder_acc_pkg holds:
  - state enum {ACCUM, HOLD}.
  - default widths SUM_W_DEF=5 and ACC_W_DEF=12.
  - CNT_W as a function of COUNT.
- One natural sub-module: acc_block_counter.
  - Inputs: clear and inc.
  - Outputs: cnt and a last flag (cnt==COUNT-1).
  - Wraps to 0 on the last increment.
- The FSM and adder remain in the top.

Test Plan:
- Reset, then feed 8 sums of 5'd3 with in_valid held high and out_ready=1 -> in_ready high for 8 cycles; out_valid for exactly 1 cycle, 1 cycle after the last accept; out_total=24, out_overflow=0.
- 8 sums of 5'd31 with out_ready=0 for 5 cycles -> out_total=248 held stable; in_ready=0 throughout HOLD; release -> next block starts with total 0.
- ACC_W=7, 8 sums of 5'd31 -> out_total=120 (248 mod 128), out_overflow=1; next block of 8x 5'd1 -> total=8, out_overflow=0.
- Accept 5 sums of 5'd10, then assert flush together with in_valid -> that input is not accepted; sample_cnt=0; a following 8x 5'd2 block yields 16.
- Assert rst in HOLD (out_ready=0) -> out_valid=0 and out_total=0 next cycle; in_ready=1.
- Random in_valid/out_ready gaps, 1000 blocks -> every total matches the scoreboard sum modulo 2^ACC_W; no sum lost or duplicated.
